// File: rtl/shift_add_mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package shift_add_mul_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mul_state_t;

    // Counter width able to hold the value word_width itself.
    function automatic int unsigned cnt_width_f(input int unsigned word_width);
        return $clog2(word_width + 1);
    endfunction

endpackage

// File: rtl/shift_add_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half through a carry-lookahead adder, then shift the whole accumulator right
// with the adder carry entering at the MSB.
module shift_add_mul_step
    import shift_add_mul_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic [2*WORD_WIDTH-1:0] acc_i,
    input  logic [WORD_WIDTH-1:0]   mcand_i,
    output logic [2*WORD_WIDTH-1:0] acc_o
);

    localparam int unsigned W = WORD_WIDTH;

    logic [W-1:0] addend;
    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;
    logic [W-1:0] sum;

    // Carry-lookahead add of acc_hi and the gated multiplicand, keeping carry out.
    always_comb begin
        addend = acc_i[0] ? mcand_i : '0;
        gen    = acc_i[2*W-1:W] & addend;
        prop   = acc_i[2*W-1:W] ^ addend;
        carry  = '0;
        for (int i = 0; i < int'(W); i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum = prop ^ carry[W-1:0];
    end

    // Shift right by one: {carry, sum} becomes the new upper W+1 bits.
    assign acc_o = {carry[W], sum, acc_i[W-1:1]};

endmodule

// File: rtl/shift_add_mul_seq.sv
// Iterative unsigned multiplier: valid/ready operand intake, WORD_WIDTH
// shift-add iterations, then a held result until the consumer takes it.
module shift_add_mul_seq
    import shift_add_mul_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = cnt_width_f(WORD_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [WORD_WIDTH-1:0]   a,
    input  logic [WORD_WIDTH-1:0]   b,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [2*WORD_WIDTH-1:0] result,
    output logic                    busy
);

    localparam int unsigned W = WORD_WIDTH;

    mul_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]       mcand_q, mcand_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [2*W-1:0]     step_acc;

    shift_add_mul_step #(
        .WORD_WIDTH (W)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (step_acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_valid)                 state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_WIDTH'(1))       state_d = ST_DONE;
            ST_DONE: if (result_ready)                state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // Output decode; result is exposed only while a product is pending.
    always_comb begin
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        result       = '0;
        case (state_q)
            ST_IDLE: start_ready = 1'b1;
            ST_RUN:  busy        = 1'b1;
            ST_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                result       = acc_q;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Datapath next values; operands are captured only on an accepted handshake.
    always_comb begin
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    mcand_d = a;
                    acc_d   = {W'(0), b};
                    cnt_d   = CNT_WIDTH'(W);
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Directed and randomized checks of shift_add_mul_seq at WORD_WIDTH=8.
module tb_shift_add_mul_seq;

    logic        clk;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    shift_add_mul_seq #(
        .WORD_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance negedges until result_valid, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (result_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_result_valid", 32'(result_valid), 32'd1);
    endtask

    // Advance negedges until start_ready, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (start_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_start_ready", 32'(start_ready), 32'd1);
    endtask

    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] vp [3];
    logic [15:0] sb [$];
    logic [15:0] exp_p;
    int n;
    int t_prev;
    int t_now;
    int seen;
    int accepted;
    int got;
    int guard;

    initial begin
        reset        = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = '0;
        b            = '0;
        va[0] = 8'd13;  vb[0] = 8'd11;  vp[0] = 16'h008F;
        va[1] = 8'h00;  vb[1] = 8'h5A;  vp[1] = 16'h0000;
        va[2] = 8'h80;  vb[2] = 8'h02;  vp[2] = 16'h0100;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Max*max with latency check
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start_valid = 1'b1; result_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; a = 'x; b = 'x;
        chk("run_start_ready", 32'(start_ready), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_result_zero", 32'(result), 32'd0);
        wait_result(n);
        chk("latency", 32'(n + 1), 32'd9);
        chk("ffxff", 32'(result), 32'h0000FE01);
        @(negedge clk);
        chk("ready_after_done", 32'(start_ready), 32'd1);
        chk("valid_after_done", 32'(result_valid), 32'd0);

        // Back-to-back with start_valid held
        start_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ready(n);
            a = va[i]; b = vb[i];
            t_now = cyc;
            if (i > 0) chk("accept_spacing", 32'(t_now - t_prev), 32'd10);
            t_prev = t_now;
            @(negedge clk);
            a = 'x; b = 'x;
            wait_result(n);
            chk("b2b_result", 32'(result), 32'(vp[i]));
        end
        start_valid = 1'b0;

        // Backpressure
        wait_ready(n);
        a = 8'h12; b = 8'h34; start_valid = 1'b1; result_ready = 1'b0;
        @(negedge clk);
        start_valid = 1'b0; a = 'x; b = 'x;
        wait_result(n);
        for (int k = 0; k < 5; k++) begin
            chk("bp_result", 32'(result), 32'h000003A8);
            chk("bp_valid", 32'(result_valid), 32'd1);
            chk("bp_start_ready", 32'(start_ready), 32'd0);
            start_valid = 1'b1; a = 8'h77; b = 8'h77;
            @(negedge clk);
        end
        chk("bp_result_end", 32'(result), 32'h000003A8);
        start_valid = 1'b0; a = 'x; b = 'x; result_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        chk("bp_no_accept_busy", 32'(busy), 32'd0);
        chk("bp_no_accept_valid", 32'(result_valid), 32'd0);

        // Reset on third RUN cycle
        wait_ready(n);
        a = 8'hAA; b = 8'h55; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; a = 'x; b = 'x;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        // Randomized traffic against a scoreboard
        accepted = 0; got = 0; guard = 0;
        while (got < 200 && guard < 20000) begin
            start_valid  = (accepted < 200) && ($urandom_range(0, 2) != 0);
            result_ready = ($urandom_range(0, 3) != 0);
            if (start_valid) begin
                a = 8'($urandom); b = 8'($urandom);
            end else begin
                a = 'x; b = 'x;
            end
            if (start_valid && start_ready === 1'b1) begin
                sb.push_back(16'(a) * 16'(b));
                accepted++;
            end
            if (result_valid === 1'b1 && result_ready) begin
                if (sb.size() == 0) begin
                    chk("rand_unexpected_result", 32'(result_valid), 32'd0);
                end else begin
                    exp_p = sb.pop_front();
                    chk("rand_result", 32'(result), 32'(exp_p));
                end
                got++;
            end
            @(negedge clk);
            guard++;
        end
        start_valid = 1'b0;
        chk("rand_accepted", 32'(accepted), 32'd200);
        chk("rand_results", 32'(got), 32'd200);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
